// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// slave is the adder side, master the surrounding datapath.
interface addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             valid_i;
    logic             ready_o;
    logic             sub_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] res_o;
    logic             carry_o;
    logic             ovf_o;
    logic             zero_o;

    modport slave (
        input  valid_i, sub_i, a_i, b_i, ready_i,
        output ready_o, valid_o, res_o, carry_o, ovf_o, zero_o
    );

    modport master (
        output valid_i, sub_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, res_o, carry_o, ovf_o, zero_o
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/sub: carry chain split into NSTAGES registered segments.
// Define ADDSUB_SAT_EN for signed saturation of res_o.
module addsub_pipe #(
    parameter int WIDTH   = 16,
    parameter int NSTAGES = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    addsub_pipe_if.slave bus
);
    localparam int SEG  = WIDTH / NSTAGES;
    localparam int LAST = NSTAGES - 1;

    logic               adv;
    logic [WIDTH-1:0]   b_eff;
    logic [NSTAGES-1:0] vld;

    assign adv         = ~bus.valid_o | bus.ready_i;
    assign bus.ready_o = adv;
    assign b_eff       = bus.sub_i ? ~bus.b_i : bus.b_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld <= '0;
        end else if (adv) begin
            vld[0] <= bus.valid_i;
            for (int k = 1; k < NSTAGES; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

    // Stage k adds segment k; operands above it ride along, finished
    // result bits below it are carried forward so the word exits whole.
    for (genvar k = 0; k < NSTAGES; k++) begin : g_st
        localparam int RW = WIDTH - k * SEG;

        logic [RW-1:0]        a_in;
        logic [RW-1:0]        b_in;
        logic                 c_in;
        logic [SEG:0]         sum;
        logic [(k+1)*SEG-1:0] r_in;

        if (k == 0) begin : g_src
            assign a_in = bus.a_i;
            assign b_in = b_eff;
            assign c_in = bus.sub_i;
            assign r_in = sum[SEG-1:0];
        end else begin : g_src
            assign a_in = g_st[k-1].g_reg.a_q;
            assign b_in = g_st[k-1].g_reg.b_q;
            assign c_in = g_st[k-1].g_reg.c_q;
            assign r_in = {sum[SEG-1:0], g_st[k-1].g_reg.r_q};
        end

        assign sum = {1'b0, a_in[SEG-1:0]}
                   + {1'b0, b_in[SEG-1:0]}
                   + {{SEG{1'b0}}, c_in};

        if (k < LAST) begin : g_reg
            logic [RW-SEG-1:0]    a_q;
            logic [RW-SEG-1:0]    b_q;
            logic                 c_q;
            logic [(k+1)*SEG-1:0] r_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                    r_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[RW-1:SEG];
                    b_q <= b_in[RW-1:SEG];
                    c_q <= sum[SEG];
                    r_q <= r_in;
                end
            end
        end
    end

    logic [WIDTH-1:0] fin;
    logic             fin_c;
    logic             fin_v;
    logic             a_msb;
    logic [WIDTH-1:0] res_d;

    assign fin   = g_st[LAST].r_in;
    assign fin_c = g_st[LAST].sum[SEG];
    assign a_msb = g_st[LAST].a_in[SEG-1];
    assign fin_v = (a_msb == g_st[LAST].b_in[SEG-1])
                && (fin[WIDTH-1] != a_msb);

`ifdef ADDSUB_SAT_EN
    // On overflow both operands share a's sign, so clamp toward it.
    assign res_d = !fin_v ? fin
                 : a_msb  ? {1'b1, {(WIDTH-1){1'b0}}}
                          : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign res_d = fin;
`endif

    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (adv) begin
            res_q   <= res_d;
            carry_q <= fin_c;
            ovf_q   <= fin_v;
            zero_q  <= ~|fin;
        end
    end

    assign bus.valid_o = vld[LAST];
    assign bus.res_o   = res_q;
    assign bus.carry_o = carry_q;
    assign bus.ovf_o   = ovf_q;
    assign bus.zero_o  = zero_q;
endmodule
